// File: rtl/sad_min_search_pkg.sv
// Shared definitions for the SAD minimum search stage: C memory geometry
// defaults (matching the SAD engine's output memory) and the FSM states.
package sad_min_search_pkg;

  localparam int SMS_N_BLK = 128;
  localparam int SMS_AW    = 7;
  localparam int SMS_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_FIN
  } sms_state_t;

endpackage

// File: rtl/sad_min_search_if.sv
// Control, C memory read port and result bus of the SAD minimum search.
interface sad_min_search_if
  import sad_min_search_pkg::*;
#(
  parameter int AW = SMS_AW,
  parameter int DW = SMS_DW
) ();

  logic          Go;
  logic [DW-1:0] Thresh;
  logic [AW-1:0] C_Addr;
  logic          C_RW;
  logic          C_En;
  logic [DW-1:0] C_Data;
  logic          Busy;
  logic          Done;
  logic [DW-1:0] Min_SAD;
  logic [AW-1:0] Min_Idx;
  logic [AW:0]   Below_Cnt;

  // Controller / memory side
  modport master (
    output Go, Thresh, C_Data,
    input  C_Addr, C_RW, C_En, Busy, Done, Min_SAD, Min_Idx, Below_Cnt
  );

  // Search engine side
  modport slave (
    input  Go, Thresh, C_Data,
    output C_Addr, C_RW, C_En, Busy, Done, Min_SAD, Min_Idx, Below_Cnt
  );

endinterface

// File: rtl/sad_min_search_cmp.sv
// Compare/accumulate datapath: running minimum, its index, and the count
// of words strictly below the threshold.
module sad_min_search_cmp #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_vld,
  input  logic [AW-1:0] i_idx,
  input  logic [DW-1:0] i_data,
  input  logic [DW-1:0] i_thresh,
  output logic [DW-1:0] o_min,
  output logic [AW-1:0] o_idx,
  output logic [AW:0]   o_cnt
);

  logic [DW-1:0] r_min;
  logic [AW-1:0] r_idx;
  logic [AW:0]   r_cnt;
  logic          r_first;

  // First valid word loads unconditionally; later words only on strict less-than
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_min   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else if (i_clr) begin
      r_min   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b1;
    end else if (i_vld) begin
      r_first <= 1'b0;
      if (r_first || (i_data < r_min)) begin
        r_min <= i_data;
        r_idx <= i_idx;
      end
      if (i_data < i_thresh) begin
        r_cnt <= r_cnt + (AW+1)'(1);
      end
    end
  end

  assign o_min = r_min;
  assign o_idx = r_idx;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/sad_min_search.sv
// Scans the C memory once per Go, reporting minimum SAD, its (lowest) index
// and the number of entries below the threshold latched at Go.
module sad_min_search
  import sad_min_search_pkg::*;
#(
  parameter int N_BLK = SMS_N_BLK,
  parameter int AW    = SMS_AW,
  parameter int DW    = SMS_DW
) (
  input logic              Clk,
  input logic              Rst,
  sad_min_search_if.slave  bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_BLK - 1);

  sms_state_t    r_state;
  sms_state_t    w_next;
  logic          w_accept;
  logic          w_fin_load;

  logic [AW-1:0] r_rd_idx;
  logic [AW-1:0] r_cmp_idx;
  logic          r_cmp_vld;
  logic [DW-1:0] r_thresh;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_min_sad;
  logic [AW-1:0] r_min_idx;
  logic [AW:0]   r_below_cnt;

  logic [DW-1:0] w_run_min;
  logic [AW-1:0] w_run_idx;
  logic [AW:0]   w_run_cnt;

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next state; DRAIN holds until the last word has been compared so that
  // FIN presents final results together with Done
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_fin_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Go) begin
          w_accept = 1'b1;
          w_next   = ST_READ;
        end
      end
      ST_READ: begin
        if (r_rd_idx == LAST_IDX) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_cmp_vld) begin
          w_fin_load = 1'b1;
          w_next     = ST_FIN;
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Address generation and compare-stage tagging of the word on C_Data
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_rd_idx  <= '0;
      r_cmp_idx <= '0;
      r_cmp_vld <= 1'b0;
    end else begin
      r_cmp_vld <= (r_state == ST_READ);
      r_cmp_idx <= r_rd_idx;
      if (w_accept) begin
        r_rd_idx <= '0;
      end else if (r_state == ST_READ) begin
        r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + AW'(1);
      end
    end
  end

  // Threshold latch, Busy/Done and result registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_thresh    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_min_sad   <= '0;
      r_min_idx   <= '0;
      r_below_cnt <= '0;
    end else begin
      r_done <= w_fin_load;
      if (w_accept) begin
        r_thresh <= bus.Thresh;
        r_busy   <= 1'b1;
      end
      if (w_fin_load) begin
        r_busy      <= 1'b0;
        r_min_sad   <= w_run_min;
        r_min_idx   <= w_run_idx;
        r_below_cnt <= w_run_cnt;
      end
    end
  end

  sad_min_search_cmp #(
    .AW (AW),
    .DW (DW)
  ) u_cmp (
    .i_clk    (Clk),
    .i_rst_n  (Rst),
    .i_clr    (w_accept),
    .i_vld    (r_cmp_vld),
    .i_idx    (r_cmp_idx),
    .i_data   (bus.C_Data),
    .i_thresh (r_thresh),
    .o_min    (w_run_min),
    .o_idx    (w_run_idx),
    .o_cnt    (w_run_cnt)
  );

  assign bus.C_Addr    = r_rd_idx;
  assign bus.C_RW      = 1'b0;
  assign bus.C_En      = (r_state == ST_READ);
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Min_SAD   = r_min_sad;
  assign bus.Min_Idx   = r_min_idx;
  assign bus.Below_Cnt = r_below_cnt;

endmodule

// File: tb/tb_sad_min_search.sv
// Bench for sad_min_search: C memory model, directed and random scans
// checked against an array-based reference computation.
module tb_sad_min_search;
  import sad_min_search_pkg::*;

  logic Clk;
  logic Rst;
  int   total = 0;
  int   bad   = 0;

  sad_min_search_if #(.AW(SMS_AW), .DW(SMS_DW)) bus ();

  sad_min_search #(.N_BLK(SMS_N_BLK), .AW(SMS_AW), .DW(SMS_DW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [31:0] mem [SMS_N_BLK];

  // Registered-read memory
  always @(posedge Clk) begin
    if (bus.C_En === 1'b1) bus.C_Data <= mem[bus.C_Addr];
  end

  // Address log, C_RW watch, cycle counter
  logic [6:0] addr_q [$];
  int rw_err = 0;
  int cyc    = 0;
  always @(posedge Clk) begin
    cyc++;
    if (bus.C_En === 1'b1) addr_q.push_back(bus.C_Addr);
    if (bus.C_RW !== 1'b0) rw_err++;
  end

  // Outputs may only move while Done is high; count Done pulses
  logic [31:0] p_min;
  logic [6:0]  p_idx;
  logic [7:0]  p_cnt;
  bit          p_vld = 0;
  int          chg_err = 0;
  int          done_cnt = 0;
  always @(negedge Clk) begin
    if (!Rst) begin
      p_vld = 0;
    end else begin
      if (p_vld && bus.Done !== 1'b1 &&
          {bus.Min_SAD, bus.Min_Idx, bus.Below_Cnt} !== {p_min, p_idx, p_cnt})
        chg_err++;
      p_vld = 1;
      p_min = bus.Min_SAD;
      p_idx = bus.Min_Idx;
      p_cnt = bus.Below_Cnt;
      if (bus.Done === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: smallest value, first position holding it, count below threshold
  function automatic void model(input logic [31:0] th, output logic [31:0] mn,
                                output logic [6:0] mi, output logic [7:0] mc);
    int first;
    mn = '1;
    foreach (mem[k]) if (mem[k] < mn) mn = mem[k];
    first = -1;
    foreach (mem[k]) if (first < 0 && mem[k] == mn) first = k;
    mi = 7'(first);
    mc = 0;
    foreach (mem[k]) if (mem[k] < th) mc++;
  endfunction

  task automatic run_scan(input string tag, input logic [31:0] th, input bit disturb,
                          output logic [31:0] o_min, output logic [6:0] o_idx,
                          output logic [7:0] o_cnt);
    logic [31:0] em;
    logic [6:0]  ei;
    logic [7:0]  ec;
    int n, st, wrong, rw0;
    bit seen;
    model(th, em, ei, ec);
    st  = addr_q.size();
    rw0 = rw_err;
    @(posedge Clk); #1;
    bus.Go = 1'b1;
    bus.Thresh = th;
    @(posedge Clk); #1;
    bus.Go = 1'b0;
    bus.Thresh = $urandom;
    chk({tag, "_busy"}, 64'(bus.Busy), 64'd1);
    n = 0;
    seen = 0;
    while (n < 300 && !seen) begin
      @(posedge Clk); #1;
      n++;
      if (bus.Done === 1'b1) seen = 1;
      bus.Go = (disturb && n == 50);
      if (disturb && n == 50) bus.Thresh = ~th;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'd130);
    chk({tag, "_busy_at_done"}, 64'(bus.Busy), 64'd0);
    chk({tag, "_min"}, 64'(bus.Min_SAD), 64'(em));
    chk({tag, "_idx"}, 64'(bus.Min_Idx), 64'(ei));
    chk({tag, "_cnt"}, 64'(bus.Below_Cnt), 64'(ec));
    o_min = bus.Min_SAD;
    o_idx = bus.Min_Idx;
    o_cnt = bus.Below_Cnt;
    @(posedge Clk); #1;
    chk({tag, "_done_width"}, 64'(bus.Done), 64'd0);
    chk({tag, "_addr_count"}, 64'(addr_q.size() - st), 64'd128);
    wrong = 0;
    for (int i = 0; i < 128; i++)
      if (st + i >= addr_q.size() || addr_q[st + i] != 7'(i)) wrong++;
    chk({tag, "_addr_seq"}, 64'(wrong), 64'd0);
    chk({tag, "_rw"}, 64'(rw_err - rw0), 64'd0);
  endtask

  initial begin
    logic [31:0] r_min, s_min, em;
    logic [6:0]  r_idx, s_idx, ei;
    logic [7:0]  r_cnt, s_cnt, ec;
    logic [31:0] th;
    int n, nd, d0;
    int t [3];

    Rst = 1'b0;
    bus.Go = 1'b0;
    bus.Thresh = '0;
    #3;
    chk("rst_addr", 64'(bus.C_Addr), 64'd0);
    chk("rst_en", 64'(bus.C_En), 64'd0);
    chk("rst_rw", 64'(bus.C_RW), 64'd0);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_min", 64'(bus.Min_SAD), 64'd0);
    chk("rst_idx", 64'(bus.Min_Idx), 64'd0);
    chk("rst_cnt", 64'(bus.Below_Cnt), 64'd0);
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b1;

    // Descending ramp
    foreach (mem[k]) mem[k] = 32'(1000 - k);
    run_scan("ramp", 32'd900, 0, r_min, r_idx, r_cnt);
    chk("ramp_min_c", 64'(r_min), 64'd873);
    chk("ramp_idx_c", 64'(r_idx), 64'd127);
    chk("ramp_cnt_c", 64'(r_cnt), 64'd27);

    // Tie: lowest index wins
    foreach (mem[k]) mem[k] = 32'd500;
    mem[40] = 32'd7;
    mem[90] = 32'd7;
    run_scan("tie", 32'd0, 0, r_min, r_idx, r_cnt);
    chk("tie_min_c", 64'(r_min), 64'd7);
    chk("tie_idx_c", 64'(r_idx), 64'd40);
    chk("tie_cnt_c", 64'(r_cnt), 64'd0);

    // All ones
    foreach (mem[k]) mem[k] = '1;
    run_scan("ones", '1, 0, r_min, r_idx, r_cnt);
    chk("ones_min_c", 64'(r_min), 64'hFFFF_FFFF);
    chk("ones_idx_c", 64'(r_idx), 64'd0);
    chk("ones_cnt_c", 64'(r_cnt), 64'd0);

    // All zero, every entry below threshold
    foreach (mem[k]) mem[k] = '0;
    run_scan("zero", 32'd1, 0, r_min, r_idx, r_cnt);
    chk("zero_idx_c", 64'(r_idx), 64'd0);
    chk("zero_cnt_c", 64'(r_cnt), 64'd128);

    // Random scans: full range, narrow range (many ties), sprinkled max values
    for (int r = 0; r < 3; r++) begin
      foreach (mem[k]) begin
        case (r)
          0: mem[k] = $urandom;
          1: mem[k] = $urandom_range(0, 15);
          default: mem[k] = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
        endcase
      end
      th = (r == 1) ? 32'($urandom_range(0, 16)) : mem[$urandom_range(0, 127)];
      run_scan($sformatf("rnd%0d", r), th, 0, r_min, r_idx, r_cnt);
    end

    // Go and Thresh disturbed mid-scan: same results as an undisturbed scan
    foreach (mem[k]) mem[k] = $urandom_range(100, 100000);
    th = 32'd50000;
    run_scan("clean", th, 0, s_min, s_idx, s_cnt);
    run_scan("disturb", th, 1, r_min, r_idx, r_cnt);
    chk("disturb_vs_clean", {r_min, 1'b0, r_idx, r_cnt}, {s_min, 1'b0, s_idx, s_cnt});
    repeat (3) @(posedge Clk);
    #1;
    chk("disturb_idle", 64'(bus.Busy), 64'd0);

    // Asynchronous reset at cycle 60 of a scan
    d0 = done_cnt;
    @(posedge Clk); #1;
    bus.Go = 1'b1;
    @(posedge Clk); #1;
    bus.Go = 1'b0;
    for (n = 1; n < 60; n++) @(posedge Clk);
    #3;
    Rst = 1'b0;
    #1;
    chk("arst_en", 64'(bus.C_En), 64'd0);
    chk("arst_addr", 64'(bus.C_Addr), 64'd0);
    chk("arst_busy", 64'(bus.Busy), 64'd0);
    chk("arst_outs", {bus.Min_SAD, 1'b0, bus.Min_Idx, bus.Below_Cnt}, 64'd0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (140) @(posedge Clk);
    #1;
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
    run_scan("post_rst", th, 0, r_min, r_idx, r_cnt);

    // Go held high: back-to-back scans
    model(th, em, ei, ec);
    @(posedge Clk); #1;
    bus.Go = 1'b1;
    bus.Thresh = th;
    nd = 0;
    for (int i = 0; i < 600 && nd < 3; i++) begin
      @(posedge Clk); #1;
      if (bus.Done === 1'b1) begin
        t[nd] = cyc;
        nd++;
        chk("b2b_min", 64'(bus.Min_SAD), 64'(em));
        chk("b2b_idx", 64'(bus.Min_Idx), 64'(ei));
        chk("b2b_cnt", 64'(bus.Below_Cnt), 64'(ec));
      end
    end
    bus.Go = 1'b0;
    chk("b2b_dones", 64'(nd), 64'd3);
    if (nd == 3) begin
      chk("b2b_period1", 64'(t[1] - t[0]), 64'd132);
      chk("b2b_period2", 64'(t[2] - t[1]), 64'd132);
    end
    repeat (5) @(posedge Clk);
    #1;
    chk("b2b_idle", 64'(bus.Busy), 64'd0);
    chk("outputs_hold", 64'(chg_err), 64'd0);
    chk("rw_always_zero", 64'(rw_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sad_min_search.md
Name: sad_min_search

Overview:
- Downstream stage of the SAD engine: after the SAD engine finishes, this block reads the 128 per-block SAD results from the output (C) memory.
- Finds the minimum SAD and its block index, and counts blocks whose SAD is below a programmable threshold.
- Results go to the motion-decision logic; single clock domain, memory read port shared with nothing else while Busy.

Parameters:
- N_BLK, 128, number of SAD entries to scan (C memory depth)
- AW, 7, C memory address width
- DW, 32, SAD word width

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-low reset
- Go  input  1  start scan; sampled in IDLE only
- Thresh  input  DW  threshold; sampled into a register on accepted Go
- C_Addr  output  AW  C memory read address
- C_RW  output  1  memory direction, always 0 (read)
- C_En  output  1  memory enable
- C_Data  input  DW  C memory read data
- Busy  output  1  high from accepted Go until Done
- Done  output  1  one-cycle pulse, results valid
- Min_SAD  output  DW  minimum SAD found
- Min_Idx  output  AW  index of minimum (lowest index on ties)
- Below_Cnt  output  AW+1  count of entries with SAD < Thresh

Behaviour:
- Reset (Rst=0, async) clears all outputs and state:
  - C_Addr=0, C_RW=0, C_En=0, Busy=0, Done=0.
  - Min_SAD=0, Min_Idx=0, Below_Cnt=0.
  - Internal counters 0; state IDLE.
- Memory timing: registered address; data for the address presented with C_En=1 in cycle t is valid on C_Data in cycle t+1.
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE:
  - C_En=0.
  - Go=1 latches Thresh, clears the internal running min/idx/count and the first flag, sets Busy, and moves to READ.
- READ:
  - Drives C_En=1, C_Addr=rd_idx; rd_idx increments each cycle.
  - When the cycle presenting address N_BLK-1 ends, moves to DRAIN.
- Compare pipeline: active in every cycle following an address issue, covering the last READ cycles and DRAIN.
  - The first compared word loads the running min/idx unconditionally.
  - Each later word replaces them only if C_Data < running_min (strict, unsigned).
  - Below count increments if C_Data < Thresh_reg (strict, unsigned).
  - cmp_idx tracks the index of the word currently on C_Data.
- DRAIN: C_En=0; performs the final compare for index N_BLK-1; moves to FIN.
- FIN:
  - Registered outputs Min_SAD, Min_Idx, Below_Cnt load the running values.
  - Done=1 for exactly this cycle; Busy drops to 0 with Done; moves to IDLE.
- Outputs hold between scans and change only in FIN.
- Latency: Go sampled at edge E0 → READ cycles E1..E128 → DRAIN → Done high in the cycle after edge E130 (131 cycles Go-to-Done).
- Go while Busy is ignored; Go held high through FIN restarts a scan on the next IDLE cycle.
- Thresh changes during a scan have no effect.
- Widths:
  - Below_Cnt is AW+1 bits so it can report 128.
  - rd_idx and cmp_idx are AW bits; terminal detection uses the index value and must not rely on wrap.
- Reset mid-scan aborts immediately; no Done; outputs return to reset values.
- All-equal data (including all 32'hFFFFFFFF) gives Min_Idx=0.

Decomposition:
- Shared package: state encoding constants (IDLE/READ/DRAIN/FIN), N_BLK/AW/DW defaults shared with the SAD engine's C memory.
- One sub-module natural: sad_min_cmp, the compare/accumulate datapath (running min, idx, below count, first flag); FSM and address generation stay in the top.

Test Plan:
- C[k]=1000-k for all k, Thresh=900 → Min_SAD=873, Min_Idx=127, Below_Cnt=27, Done pulse 131 cycles after Go, single cycle.
- C[k]=500 except C[40]=7 and C[90]=7, Thresh=0 → Min_SAD=7, Min_Idx=40, Below_Cnt=0.
- All C[k]=32'hFFFFFFFF, Thresh=32'hFFFFFFFF → Min_SAD=32'hFFFFFFFF, Min_Idx=0, Below_Cnt=0; all C[k]=0, Thresh=1 → Below_Cnt=128.
- Go pulsed again at cycle 50 of a scan, Thresh changed mid-scan → ignored; results match first scan; C_Addr sequence 0..127 exactly once, C_RW always 0.
- Rst low at cycle 60 of a scan → all outputs 0 asynchronously (before next edge); no Done; a fresh Go afterward completes normally.
- Go held high continuously → back-to-back scans, Done every 132 cycles, outputs change only in FIN.
